// File: rtl/pkt_tx_shaper_if.sv
// Byte-stream ingress and cdc_ip egress signals of the transmit shaper.
// The shaper drives the slave side; the upstream source and cdc_ip use the master side.
interface pkt_tx_shaper_if #(
  parameter int unsigned WIDTH = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             data_valid_a;
  logic [WIDTH-1:0] data_a;
  logic             sof_a;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, data_valid_a, data_a, sof_a
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, data_valid_a, data_a, sof_a
  );
endinterface

// File: rtl/pkt_tx_shaper.sv
// Store-and-forward frame shaper: buffers one frame, pads it to MIN_BYTES,
// emits it as a gap-free burst to cdc_ip and enforces IPG idle cycles between frames.
module pkt_tx_shaper #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BYTES = 64,
  parameter int unsigned MIN_BYTES = 42,
  parameter int unsigned IPG       = 10
) (
  input  logic              clk_a,
  input  logic              rst,
  pkt_tx_shaper_if.slave    bus,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);
  localparam int unsigned AW    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int unsigned GAP_W = (IPG > 1) ? $clog2(IPG) : 1;

  typedef enum logic [1:0] {FILL, SEND, GAP, DROP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] wr_cnt, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_d;
  logic [CNT_W-1:0] len, len_d;
  logic [CNT_W-1:0] out_len;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
  logic             s_ready_d;
  logic             valid_d;
  logic             sof_d;
  logic [WIDTH-1:0] data_d;
  logic [15:0]      frame_cnt_d, drop_cnt_d;
  logic             wr_en;
  logic             accept;
  logic [WIDTH-1:0] rd_byte;
  logic [WIDTH-1:0] buf_mem [MAX_BYTES];

  assign accept  = bus.s_valid & bus.s_ready;
  assign out_len = (len < CNT_W'(MIN_BYTES)) ? CNT_W'(MIN_BYTES) : len;
  assign rd_byte = buf_mem[AW'(rd_cnt)];

  // Frame buffer: no reset, contents are only read back after a complete fill
  always_ff @(posedge clk_a) begin
    if (wr_en) buf_mem[AW'(wr_cnt)] <= bus.s_data;
  end

  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      state            <= FILL;
      wr_cnt           <= '0;
      rd_cnt           <= '0;
      len              <= '0;
      gap_cnt          <= '0;
      bus.s_ready      <= 1'b0;
      bus.data_valid_a <= 1'b0;
      bus.data_a       <= '0;
      bus.sof_a        <= 1'b0;
      frame_cnt        <= '0;
      drop_cnt         <= '0;
    end else begin
      state            <= state_d;
      wr_cnt           <= wr_cnt_d;
      rd_cnt           <= rd_cnt_d;
      len              <= len_d;
      gap_cnt          <= gap_cnt_d;
      bus.s_ready      <= s_ready_d;
      bus.data_valid_a <= valid_d;
      bus.data_a       <= data_d;
      bus.sof_a        <= sof_d;
      frame_cnt        <= frame_cnt_d;
      drop_cnt         <= drop_cnt_d;
    end
  end

  // Next state, counters and the registered output values
  always_comb begin
    state_d     = state;
    wr_cnt_d    = wr_cnt;
    rd_cnt_d    = rd_cnt;
    len_d       = len;
    gap_cnt_d   = gap_cnt;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    data_d      = '0;
    frame_cnt_d = frame_cnt;
    drop_cnt_d  = drop_cnt;
    wr_en       = 1'b0;

    unique case (state)
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (bus.s_last) begin
            len_d    = wr_cnt + CNT_W'(1);
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            state_d  = SEND;
          end else if (wr_cnt == CNT_W'(MAX_BYTES - 1)) begin
            state_d = DROP;
            if (drop_cnt != 16'hFFFF) drop_cnt_d = drop_cnt + 16'd1;
          end else begin
            wr_cnt_d = wr_cnt + CNT_W'(1);
          end
        end
      end
      DROP: begin
        if (accept && bus.s_last) begin
          wr_cnt_d = '0;
          state_d  = FILL;
        end
      end
      SEND: begin
        valid_d = 1'b1;
        sof_d   = (rd_cnt == '0);
        data_d  = (rd_cnt < len) ? rd_byte : '0;
        if (rd_cnt == out_len - CNT_W'(1)) begin
          rd_cnt_d  = '0;
          gap_cnt_d = '0;
          state_d   = GAP;
          if (frame_cnt != 16'hFFFF) frame_cnt_d = frame_cnt + 16'd1;
        end else begin
          rd_cnt_d = rd_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(IPG - 1)) begin
          gap_cnt_d = '0;
          state_d   = FILL;
        end else begin
          gap_cnt_d = gap_cnt + GAP_W'(1);
        end
      end
      default: state_d = FILL;
    endcase

    s_ready_d = (state_d == FILL) || (state_d == DROP);
  end

endmodule
